// File: rtl/core_pkg.sv
// Shared core parameters: datapath/address widths common to regfile32 and alu32,
// plus the architectural zero-register address.
package core_pkg;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int NREGS = 1 << AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage : core_pkg

// File: rtl/flag_reg.sv
// Two-bit enabled status register with synchronous active-high reset.
// Used for the carry/zero flags; intended for reuse by other status bits.
module flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : flag_reg

// File: rtl/regfile32.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero, and a registered carry/zero flag pair.
module regfile32 #(
  parameter int WIDTH = core_pkg::WIDTH,
  parameter int AW    = core_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    iRs1,
  input  logic [AW-1:0]    iRs2,
  input  logic [AW-1:0]    iRd,
  input  logic             iWe,
  input  logic [WIDTH-1:0] iWd,
  input  logic             iFlagWe,
  input  logic             iCarry,
  input  logic             iZero,
  output logic [WIDTH-1:0] oA,
  output logic [WIDTH-1:0] oB,
  output logic             oCarryQ,
  output logic             oZeroQ
);

  import core_pkg::REG_ZERO;

  localparam int NREGS = 1 << AW;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [1:0]       w_flags;

  // NOTE: the array is kept in flops (async two-port read), so it can and must be
  // reset explicitly; a RAM-inferred array would not accept a reset loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (iWe && (iRd != REG_ZERO)) begin
      r_regs[iRd] <= iWd;
    end
  end

  // Reads see only stored state: forwarding iWd here would close the ALU loop.
  assign oA = (iRs1 == REG_ZERO) ? '0 : r_regs[iRs1];
  assign oB = (iRs2 == REG_ZERO) ? '0 : r_regs[iRs2];

  flag_reg u_flag_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (iFlagWe),
    .i_d  ({iCarry, iZero}),
    .o_q  (w_flags)
  );

  assign oCarryQ = w_flags[1];
  assign oZeroQ  = w_flags[0];

endmodule : regfile32
